// File: rtl/axis_packet_arbiter.sv
// axis_packet_arbiter: round-robin, packet-locked merge of N AXI-Stream inputs into one registered output
module axis_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH = 40,
  parameter int N_PORTS = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [N_PORTS*AXIS_DATA_WIDTH-1:0] s_tdata_i,
  input  logic [N_PORTS-1:0]                 s_tlast_i,
  input  logic [N_PORTS-1:0]                 s_tvalid_i,
  output logic [N_PORTS-1:0]                 s_tready_o,
  output logic [AXIS_DATA_WIDTH-1:0]         m_tdata_o,
  output logic                               m_tlast_o,
  output logic                               m_tvalid_o,
  input  logic                               m_tready_i,
  output logic [N_PORTS-1:0]                 grant_o,
  output logic                               busy_o
);
  localparam int IW = $clog2(N_PORTS);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t state;
  logic [IW-1:0] last_grant, owner, pick;
  logic found, xfer, beat_last;
  logic [AXIS_DATA_WIDTH-1:0] beat_data;
  // first valid port strictly after the previous winner, wrapping
  always_comb begin
    pick = last_grant;
    found = 1'b0;
    for (int k = 1; k <= N_PORTS; k++)
      if (!found && s_tvalid_i[(int'(last_grant) + k) % N_PORTS]) begin
        found = 1'b1;
        pick = IW'((int'(last_grant) + k) % N_PORTS);
      end
  end
  assign s_tready_o = (state == LOCK && (!m_tvalid_o || m_tready_i)) ? grant_o : '0;
  assign xfer       = |(s_tvalid_i & s_tready_o);
  assign beat_data  = s_tdata_i[owner*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign beat_last  = s_tlast_i[owner];
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= IW'(N_PORTS - 1);
      owner      <= '0;
      grant_o    <= '0;
      busy_o     <= 1'b0;
      m_tdata_o  <= '0;
      m_tlast_o  <= 1'b0;
      m_tvalid_o <= 1'b0;
    end else begin
      if (xfer) begin
        m_tdata_o  <= beat_data;
        m_tlast_o  <= beat_last;
        m_tvalid_o <= 1'b1;
      end else if (m_tready_i) begin
        m_tvalid_o <= 1'b0;
      end
      if (state == IDLE) begin
        if (found) begin
          state   <= LOCK;
          owner   <= pick;
          grant_o <= {{(N_PORTS-1){1'b0}}, 1'b1} << pick;
          busy_o  <= 1'b1;
        end
      end else if (xfer && beat_last) begin
        state      <= IDLE;
        last_grant <= owner;
        grant_o    <= '0;
        busy_o     <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_axis_packet_arbiter.sv
// tb_axis_packet_arbiter: directed scenarios plus randomized traffic against a packet-level arbiter model
module tb_axis_packet_arbiter;
  localparam int N = 4;
  localparam int W = 40;
  logic clk = 1'b0;
  logic rst;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0] s_tlast, s_tvalid, s_tready, grant;
  logic [W-1:0] m_tdata;
  logic m_tlast, m_tvalid, m_tready, busy;
  int checks = 0, errors = 0;
  int cyc = 0, fixed_len = 0;
  int src_len[N], src_idx[N], src_pkt[N];
  bit md_lock, md_v, md_l;
  int md_owner, md_last;
  logic [W-1:0] md_d;
  logic [N-1:0] e_grant, e_ready;
  logic e_busy;
  logic [W-1:0] outq[$];
  logic outl[$];
  int outt[$];

  always #5 clk = ~clk;

  axis_packet_arbiter #(.AXIS_DATA_WIDTH(W), .N_PORTS(N)) dut (
    .clk_i(clk), .rst_i(rst), .s_tdata_i(s_tdata), .s_tlast_i(s_tlast),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready), .m_tdata_o(m_tdata),
    .m_tlast_o(m_tlast), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .grant_o(grant), .busy_o(busy)
  );

  // beat payload identifies port, packet number and beat index
  function automatic logic [W-1:0] beat(int p, int pk, int i);
    return {8'(p), 16'(pk), 16'(i)};
  endfunction

  task automatic start_pkt(input int p, input int len);
    src_len[p] = len;
    src_idx[p] = 0;
    src_pkt[p]++;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic r);
    for (int p = 0; p < N; p++) begin
      s_tdata[p*W +: W] = beat(p, src_pkt[p], src_idx[p]);
      s_tlast[p] = (src_idx[p] == src_len[p] - 1);
    end
    s_tvalid = v;
    m_tready = r;
    #1;
    e_busy  = md_lock;
    e_grant = md_lock ? N'(1) << md_owner : '0;
    e_ready = (md_lock && (!md_v || m_tready)) ? e_grant : '0;
  endtask

  // advance model and sources across one rising edge
  task automatic tick();
    logic [N-1:0] hs;
    bit x;
    hs = s_tvalid & s_tready;
    if (m_tvalid && m_tready && !rst) begin
      outq.push_back(m_tdata);
      outl.push_back(m_tlast);
      outt.push_back(cyc);
    end
    if (rst) begin
      md_lock = 0; md_last = N - 1; md_v = 0; md_d = '0; md_l = 0;
    end else begin
      x = md_lock && e_ready[md_owner] && s_tvalid[md_owner];
      if (x) begin
        md_v = 1; md_d = s_tdata[md_owner*W +: W]; md_l = s_tlast[md_owner];
      end else if (m_tready) md_v = 0;
      if (md_lock) begin
        if (x && s_tlast[md_owner]) begin
          md_lock = 0; md_last = md_owner;
        end
      end else begin
        for (int k = 1; k <= N; k++)
          if (s_tvalid[(md_last + k) % N]) begin
            md_owner = (md_last + k) % N; md_lock = 1; break;
          end
      end
    end
    for (int p = 0; p < N; p++)
      if (hs[p] && !rst) begin
        if (s_tlast[p]) start_pkt(p, fixed_len != 0 ? fixed_len : int'($urandom_range(1, 4)));
        else src_idx[p]++;
      end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      drive(grant, 1'b1);
      if (!busy && !m_tvalid) return;
      tick();
    end
    checks++; errors++;
    $display("FAIL drain_timeout busy=%b m_tvalid=%b required idle", busy, m_tvalid);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) begin drive(N'($urandom), 1'($urandom)); tick(); end
    checks++;
    if ({grant, busy, s_tready} !== '0) begin
      errors++; $display("FAIL reset_ctl grant=%b busy=%b s_tready=%b required 0", grant, busy, s_tready);
    end
    checks++;
    if ({m_tvalid, m_tlast, m_tdata} !== '0) begin
      errors++; $display("FAIL reset_out m_tvalid=%b m_tlast=%b m_tdata=%h required 0", m_tvalid, m_tlast, m_tdata);
    end
    rst = 0;
    drive('0, 1'b1);
    tick();
  endtask

  task automatic test_round_robin();
    int n, prev;
    n = 0; prev = 0;
    fixed_len = 2;
    for (int p = 0; p < N; p++) start_pkt(p, 2);
    outq.delete(); outl.delete(); outt.delete();
    repeat (24) begin drive('1, 1'b1); tick(); end
    drain();
    fixed_len = 0;
    for (int i = 0; i < outq.size(); i++)
      if (outl[i]) begin
        checks++;
        if (i == 0 || outq[i][39:32] !== 8'(n % N) || outq[i][15:0] !== 16'd1 ||
            outq[i-1][39:32] !== 8'(n % N) || outq[i-1][15:0] !== 16'd0 || outl[i-1]) begin
          errors++; $display("FAIL rr_order pkt=%0d got=%h required port %0d", n, outq[i], n % N);
        end
        if (n > 0) begin
          checks++;
          if (outt[i] - prev != 3) begin
            errors++; $display("FAIL rr_gap pkt=%0d spacing=%0d required 3", n, outt[i] - prev);
          end
        end
        prev = outt[i];
        n++;
      end
    checks++;
    if (n != 8) begin errors++; $display("FAIL rr_count got=%0d required 8", n); end
  endtask

  task automatic test_single_port();
    int pk;
    start_pkt(2, 3);
    pk = src_pkt[2];
    for (int c = 0; c < 6; c++) begin
      drive(c < 4 ? 4'b0100 : 4'b0000, 1'b1);
      checks++;
      if (grant !== ((c >= 1 && c <= 3) ? 4'b0100 : 4'b0000) || busy !== (c >= 1 && c <= 3)) begin
        errors++; $display("FAIL sp_grant cyc=%0d grant=%b busy=%b", c, grant, busy);
      end
      checks++;
      if (m_tvalid !== (c >= 2 && c <= 4) ||
          (m_tvalid && (m_tdata !== beat(2, pk, c - 2) || m_tlast !== (c == 4)))) begin
        errors++; $display("FAIL sp_data cyc=%0d valid=%b data=%h last=%b required %h", c, m_tvalid, m_tdata, m_tlast, beat(2, pk, c - 2));
      end
      tick();
    end
  endtask

  task automatic test_wrap();
    start_pkt(3, 1);
    drive(4'b1000, 1'b1); tick();
    drain();
    start_pkt(0, 2);
    drive(4'b1001, 1'b1); tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL wrap grant=%b required 0001", grant); end
    drain();
  endtask

  task automatic test_stall();
    int i;
    start_pkt(1, 3);
    drive(4'b0010, 1'b1); tick();
    checks++;
    if (grant !== 4'b0010) begin errors++; $display("FAIL stall_grant grant=%b required 0010", grant); end
    drive(4'b1010, 1'b1); tick();
    repeat (4) begin
      drive(4'b1000, 1'b1);
      checks++;
      if (grant !== 4'b0010 || s_tready[3] !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL stall_hold grant=%b s_tready=%b required grant 0010", grant, s_tready);
      end
      tick();
    end
    for (i = 0; i < 10; i++) begin
      drive(4'b1010, 1'b1);
      if (!busy) break;
      tick();
    end
    checks++;
    if (i == 10) begin errors++; $display("FAIL stall_release busy=%b required 0", busy); end
    tick();
    checks++;
    if (grant !== 4'b1000) begin errors++; $display("FAIL stall_next grant=%b required 1000", grant); end
    drain();
  endtask

  task automatic test_backpressure();
    int pk;
    start_pkt(0, 6);
    pk = src_pkt[0];
    outq.delete(); outl.delete(); outt.delete();
    repeat (3) begin drive(4'b0001, 1'b1); tick(); end
    repeat (5) begin
      drive(4'b0001, 1'b0);
      checks++;
      if (m_tvalid !== 1'b1 || m_tdata !== beat(0, pk, 1) || s_tready !== 4'b0000) begin
        errors++; $display("FAIL bp_hold valid=%b data=%h s_tready=%b required %h", m_tvalid, m_tdata, s_tready, beat(0, pk, 1));
      end
      tick();
    end
    drain();
    checks++;
    if (outq.size() != 6) begin errors++; $display("FAIL bp_count got=%0d required 6", outq.size()); end
    else
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (outq[k] !== beat(0, pk, k) || outl[k] !== (k == 5)) begin
          errors++; $display("FAIL bp_beat k=%0d got=%h last=%b required %h", k, outq[k], outl[k], beat(0, pk, k));
        end
      end
  endtask

  task automatic test_reset_mid();
    start_pkt(0, 4);
    repeat (3) begin drive(4'b0001, 1'b1); tick(); end
    drive(4'b0001, 1'b1);
    rst = 1; tick(); rst = 0;
    drive('0, 1'b1);
    checks++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || grant !== '0 || s_tready !== '0) begin
      errors++; $display("FAIL rstmid_out valid=%b busy=%b grant=%b required 0", m_tvalid, busy, grant);
    end
    start_pkt(0, 2);
    start_pkt(1, 2);
    drive(4'b0011, 1'b1); tick();
    checks++;
    if (grant !== 4'b0001) begin errors++; $display("FAIL rstmid_grant grant=%b required 0001", grant); end
    drain();
  endtask

  task automatic test_random();
    repeat (500) begin
      drive(N'($urandom), $urandom_range(0, 3) != 0);
      checks++;
      if ({grant, busy, s_tready, m_tvalid} !== {e_grant, e_busy, e_ready, md_v}) begin
        errors++; $display("FAIL rand_ctl cyc=%0d grant=%b busy=%b rdy=%b mv=%b required %b %b %b %b",
                           cyc, grant, busy, s_tready, m_tvalid, e_grant, e_busy, e_ready, md_v);
      end
      if (md_v) begin
        checks++;
        if ({m_tdata, m_tlast} !== {md_d, md_l}) begin
          errors++; $display("FAIL rand_data cyc=%0d got=%h/%b required %h/%b", cyc, m_tdata, m_tlast, md_d, md_l);
        end
      end
      tick();
    end
    drain();
  endtask

  initial begin
    rst = 1; s_tdata = '0; s_tlast = '0; s_tvalid = '0; m_tready = 1'b0;
    md_lock = 0; md_v = 0; md_l = 0; md_owner = 0; md_last = N - 1; md_d = '0;
    for (int p = 0; p < N; p++) begin src_pkt[p] = 0; start_pkt(p, 2); end
    test_reset();
    test_round_robin();
    test_single_port();
    test_wrap();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
